// File: rtl/uart_boot_loader.sv
// uart_boot_loader: packs UART bytes (first byte = LSB) into 32-bit words and writes them
// to instruction memory while the CPU is held off. The CPU is released when the host goes
// idle, or when the memory fills up. A reload pulse in DONE restarts loading.
// Build option: define UART_BOOT_LOADER_CHECKSUM_EN to add a mod-256 byte checksum output.
// With that option, the CPU stays held if the checksum does not match i_expected_sum.
module uart_boot_loader #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  i_clk_uart,
  input  logic                  i_rst,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  input  logic                  i_clear_sign,
  input  logic                  i_reload,
  input  logic                  i_mem_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  input  logic [7:0]            i_expected_sum,
  output logic [7:0]            o_checksum,
`endif
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH:0]   CapWords = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            pend_data_q, pend_data_d;
  logic                  clear_cause_q, clear_cause_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  // State register with synchronous reset; reset wins over every other event.
  always_ff @(posedge i_clk_uart) begin
    if (i_rst) begin
      state_q       <= StIdle;
      idx_q         <= 2'd0;
      wdata_q       <= 32'd0;
      addr_q        <= BASE_ADDR;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      hold_q        <= 1'b1;
      done_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_data_q   <= 8'd0;
      clear_cause_q <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
      pend_valid_q  <= pend_valid_d;
      pend_data_q   <= pend_data_d;
      clear_cause_q <= clear_cause_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Next-state logic: byte packing, write handshake, pending buffer and load completion.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    addr_d        = addr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    hold_d        = hold_q;
    done_d        = done_q;
    pend_valid_d  = pend_valid_q;
    pend_data_d   = pend_data_q;
    clear_cause_d = clear_cause_q;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          wdata_d = {24'd0, i_data};
          idx_d   = 2'd1;
          state_d = StCollect;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          csum_d  = csum_q + i_data;
`endif
        end
      end

      StCollect: begin
        if (pend_valid_q) begin
          // Pending bytes only exist right after a write, so idx_q is 0 here. A byte
          // arriving in the same cycle lands in lane 1 so nothing lags behind.
          pend_valid_d  = 1'b0;
          wdata_d[7:0]  = pend_data_q;
          idx_d         = 2'd1;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          csum_d        = csum_q + pend_data_q;
`endif
          if (i_valid) begin
            wdata_d[15:8] = i_data;
            idx_d         = 2'd2;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            csum_d        = csum_q + pend_data_q + i_data;
`endif
          end
        end else if (i_valid) begin
          wdata_d[{idx_q, 3'b000} +: 8] = i_data;
          idx_d = idx_q + 2'd1;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          csum_d = csum_q + i_data;
`endif
          if (idx_q == 2'd3) begin
            state_d       = StWrite;
            clear_cause_d = 1'b0;
          end
        end else if (i_clear_sign) begin
          if (idx_q != 2'd0) begin
            state_d       = StWrite;
            clear_cause_d = 1'b1;
          end else begin
            state_d = StDone;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      StWrite: begin
        if (i_valid) begin
          if (pend_valid_q) begin
            overflow_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_data_d  = i_data;
          end
        end
        if (i_mem_ready) begin
          addr_d  = addr_q + 1'b1;
          count_d = (count_q == CapWords) ? count_q : count_q + 1'b1;
          wdata_d = 32'd0;
          idx_d   = 2'd0;
          if (clear_cause_q || (addr_q == LastAddr)) begin
            state_d      = StDone;
            hold_d       = 1'b0;
            done_d       = 1'b1;
            // Any byte still waiting has nowhere to go.
            if (pend_valid_q || i_valid) begin
              overflow_d = 1'b1;
            end
            pend_valid_d = 1'b0;
          end else begin
            state_d = StCollect;
          end
        end
      end

      StDone: begin
        if (i_reload) begin
          state_d      = StIdle;
          addr_d       = BASE_ADDR;
          count_d      = '0;
          overflow_d   = 1'b0;
          hold_d       = 1'b1;
          done_d       = 1'b0;
          idx_d        = 2'd0;
          wdata_d      = 32'd0;
          pend_valid_d = 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          csum_d       = 8'd0;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign o_mem_we     = (state_q == StWrite);
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_load_done  = done_q;
  assign o_word_count = count_q;
  assign o_overflow   = overflow_q;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  assign o_checksum = csum_q;
  // A checksum mismatch keeps the CPU off even though loading has finished.
  assign o_cpu_hold = hold_q | (done_q & (csum_q != i_expected_sum));
`else
  assign o_cpu_hold = hold_q;
`endif

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Sequences the UART receiver's byte stream into 32-bit words and writes them into instruction memory, with the CPU held off during loading.
- Sits between the UART receiver (byte, valid pulse, idle-clear sign) and the instruction-memory write port.
- Releases the CPU once the host stops transmitting.
- Restartable via a reload pulse without a global reset.

Parameters:
ADDR_WIDTH, 8, word-address width; capacity = 2**ADDR_WIDTH words
BASE_ADDR, 0, first word address written after reset/reload (ADDR_WIDTH bits)

Ports:
i_clk_uart  input  1  single system clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_data  input  8  received byte from UART receiver
i_valid  input  1  one-cycle strobe, i_data valid
i_clear_sign  input  1  level, host idle timeout reached after ≥1 byte
i_reload  input  1  one-cycle pulse, restart load (honoured only in DONE)
i_mem_ready  input  1  memory accepts write this cycle
o_mem_we  output  1  write request, held until accepted
o_mem_addr  output  ADDR_WIDTH  word address
o_mem_wdata  output  32  assembled word
o_cpu_hold  output  1  1 = CPU held in reset / off memory
o_load_done  output  1  1 = load complete
o_word_count  output  ADDR_WIDTH+1  words written this load
o_overflow  output  1  sticky: byte dropped or capacity exceeded

Behaviour:
- Clock and reset: one clock i_clk_uart; reset i_rst is synchronous and active-high. All state updates on the rising edge.
- Reset values:
  - o_mem_we=0, o_mem_addr=BASE_ADDR, o_mem_wdata=0.
  - o_cpu_hold=1, o_load_done=0, o_word_count=0, o_overflow=0.
  - byte index=0, pending buffer empty, state IDLE.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: wait for first i_valid. i_clear_sign is ignored here. The first byte goes to COLLECT.
- Byte placement: byte n of a word (n=0..3) is placed at o_mem_wdata[8n+7:8n], so the first-received byte is the LSB. Index increments per byte.
- COLLECT:
  - Fourth byte → WRITE on the next cycle.
  - i_clear_sign with index>0 → WRITE. Unfilled bytes stay 0; the word buffer is cleared on entry to COLLECT.
  - i_clear_sign with index==0 → DONE.
- WRITE:
  - o_mem_we=1 with stable addr/wdata until a cycle with i_mem_ready=1; that cycle is the single accepted write.
  - Next cycle: we=0, addr+1, count+1, wdata cleared, index=0.
  - Then → DONE if clear was the cause or capacity is reached; otherwise → COLLECT.
  - Minimum latency from 4th-byte strobe to o_mem_we=1: 1 cycle.
- Pending buffer:
  - A byte arriving during WRITE is latched into a one-entry pending buffer and consumed as byte 0 on the first COLLECT cycle.
  - A further arrival while pending is full: byte dropped, o_overflow=1.
- Capacity:
  - The write at address 2**ADDR_WIDTH-1 is the last write; o_mem_addr then wraps to 0 (mod 2**ADDR_WIDTH).
  - The state goes to DONE. If bytes remain pending or arrive before DONE, o_overflow=1.
  - o_word_count saturates at 2**ADDR_WIDTH.
- DONE:
  - o_cpu_hold=0 and o_load_done=1, both registered, asserted the cycle DONE is entered. i_valid is ignored.
  - i_reload → IDLE with addr=BASE_ADDR, count=0, overflow=0, hold=1, done=0.
  - i_reload outside DONE is ignored.
- Simultaneous events:
  - i_valid with i_clear_sign in the same cycle: the byte is taken and clear is ignored that cycle.
  - i_rst with anything: reset wins.
- Reset mid-WRITE: o_mem_we drops on the next edge and the partial word is discarded.

Optional Feature:
UART_BOOT_LOADER_CHECKSUM_EN
- With the macro defined:
  - Adds output o_checksum [7:0], the mod-256 sum of every accepted byte of the current load (dropped bytes excluded).
  - Reset/reload value is 0; it is frozen in DONE.
  - Adds input i_expected_sum [7:0]. In DONE, if o_checksum != i_expected_sum, o_cpu_hold stays 1 (o_load_done still 1).
- Without the macro: neither port exists and DONE always releases o_cpu_hold.

Test Plan:
1. Stream 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00, then i_clear_sign, i_mem_ready=1 → mem[0]=0x00000013, mem[1]=0x00100093; count=2; hold=0; done=1.
2. Five bytes 0xAA,0xBB,0xCC,0xDD,0xEE then clear → mem[0]=0xDDCCBBAA, mem[1]=0x000000EE; count=2.
3. i_mem_ready low 5 cycles during WRITE while one byte 0x55 arrives → we held 5 cycles, exactly one write, 0x55 becomes byte 0 of the next word; overflow=0. Send two bytes instead → second dropped, overflow=1.
4. ADDR_WIDTH=2, send 20 bytes → 4 writes at addr 0..3, DONE; count=4; overflow=1; addr wraps to 0.
5. Assert i_rst with o_mem_we=1 → next cycle we=0, addr=BASE_ADDR, hold=1. Then i_reload in DONE after a completed load → count=0 and a reload of 4 bytes writes at BASE_ADDR.
6. With UART_BOOT_LOADER_CHECKSUM_EN, bytes 0xFF,0x02,0x00,0x00 then clear:
   - o_checksum=0x01.
   - i_expected_sum=0x01 → hold=0.
   - i_expected_sum=0x02 → hold=1, done=1.
